// File: rtl/latch_arbiter.sv
// Round-robin arbiter and write sequencer for a shared holding register.
// One requester at a time is granted, its data loaded into Q, then priority rotates.
module latch_arbiter #(
  parameter int unsigned NREQ  = 4,
  parameter int unsigned WIDTH = 8,
  localparam int unsigned OW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic                  Clock,
  input  logic                  Resetn,
  input  logic [NREQ-1:0]       Req,
  input  logic [NREQ*WIDTH-1:0] Din,
  input  logic                  Hold,
  output logic [WIDTH-1:0]      Q,
  output logic [NREQ-1:0]       Grant,
  output logic [NREQ-1:0]       Ack,
  output logic [OW-1:0]         Owner,
  output logic                  Busy
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_LOAD    = 2'd1,
    S_RELEASE = 2'd2
  } state_t;

  state_t           state_q;
  logic [WIDTH-1:0] q_q;
  logic [NREQ-1:0]  grant_q;
  logic [NREQ-1:0]  ack_q;
  logic [OW-1:0]    owner_q;
  logic [OW-1:0]    ptr_q;
  logic             busy_q;

  logic             win_vld_d;
  logic [OW-1:0]    win_idx_d;
  logic [NREQ-1:0]  win_oh_d;
  logic [OW-1:0]    ptr_d;
  logic [31:0]      idx;

  // Rotating search: first set request at Ptr, Ptr+1, ... modulo NREQ.
  always_comb begin
    win_vld_d = 1'b0;
    win_idx_d = '0;
    idx       = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      idx = (32'(ptr_q) + 32'(i)) % 32'(NREQ);
      if (!win_vld_d && Req[OW'(idx)]) begin
        win_vld_d = 1'b1;
        win_idx_d = OW'(idx);
      end
    end
    win_oh_d = NREQ'(1) << win_idx_d;
    ptr_d    = (32'(owner_q) == 32'(NREQ - 1)) ? '0 : owner_q + OW'(1);
  end

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      state_q <= S_IDLE;
      q_q     <= '0;
      grant_q <= '0;
      ack_q   <= '0;
      owner_q <= '0;
      ptr_q   <= '0;
      busy_q  <= 1'b0;
    end else begin
      ack_q <= '0;
      case (state_q)
        S_IDLE: begin
          if (!Hold && win_vld_d) begin
            grant_q <= win_oh_d;
            owner_q <= win_idx_d;
            busy_q  <= 1'b1;
            state_q <= S_LOAD;
          end
        end
        S_LOAD: begin
          // A withdrawn request aborts without touching Q or priority.
          if (Req[owner_q]) begin
            q_q     <= Din[32'(owner_q)*WIDTH +: WIDTH];
            ack_q   <= grant_q;
            ptr_q   <= ptr_d;
            state_q <= S_RELEASE;
          end else begin
            grant_q <= '0;
            busy_q  <= 1'b0;
            state_q <= S_IDLE;
          end
        end
        S_RELEASE: begin
          if (!Req[owner_q]) begin
            grant_q <= '0;
            busy_q  <= 1'b0;
            state_q <= S_IDLE;
          end
        end
        default: begin
          grant_q <= '0;
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign Q     = q_q;
  assign Grant = grant_q;
  assign Ack   = ack_q;
  assign Owner = owner_q;
  assign Busy  = busy_q;

endmodule

// File: tb/tb_latch_arbiter.sv
// Bench for latch_arbiter: directed scenarios then random transactions
// checked against a round-robin reference model.
module tb_latch_arbiter;
  localparam int unsigned NREQ  = 4;
  localparam int unsigned WIDTH = 8;

  logic        Clock = 1'b0;
  logic        Resetn;
  logic [3:0]  Req;
  logic [31:0] Din;
  logic        Hold;
  logic [7:0]  Q;
  logic [3:0]  Grant;
  logic [3:0]  Ack;
  logic [1:0]  Owner;
  logic        Busy;

  int n_chk  = 0;
  int n_fail = 0;

  int         m_ptr;
  logic [7:0] m_q;
  logic [7:0] din_arr [4];
  bit         scramble;

  latch_arbiter #(.NREQ(NREQ), .WIDTH(WIDTH)) dut (
    .Clock (Clock),
    .Resetn(Resetn),
    .Req   (Req),
    .Din   (Din),
    .Hold  (Hold),
    .Q     (Q),
    .Grant (Grant),
    .Ack   (Ack),
    .Owner (Owner),
    .Busy  (Busy)
  );

  always #5 Clock = ~Clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge Clock);
    #1;
  endtask

  task automatic apply_din();
    Din = {din_arr[3], din_arr[2], din_arr[1], din_arr[0]};
  endtask

  task automatic rand_din();
    for (int i = 0; i < 4; i++) din_arr[i] = 8'($urandom);
    apply_din();
  endtask

  function automatic logic [3:0] oh(input int i);
    logic [3:0] r;
    r    = '0;
    r[i] = 1'b1;
    return r;
  endfunction

  // Reference priority rule: first requester at or after the pointer, wrapping.
  function automatic int rr_pick(input logic [3:0] r, input int p);
    for (int k = 0; k < 4; k++)
      if (r[(p + k) % 4]) return (p + k) % 4;
    return -1;
  endfunction

  // One full contest starting from IDLE with Req/Din already driven.
  task automatic txn(input int extra_rel, input bit abort_it, input bit hold_in_load,
                     input bit restore);
    int         w;
    logic [7:0] exp_d;
    w     = rr_pick(Req, m_ptr);
    exp_d = din_arr[w];
    step();
    chk("grant_k", 32'(Grant), 32'(oh(w)));
    chk("owner_k", 32'(Owner), 32'(w));
    chk("busy_k",  32'(Busy),  32'd1);
    chk("ack_k",   32'(Ack),   32'd0);
    chk("q_k",     32'(Q),     32'(m_q));
    if (hold_in_load) Hold = 1'b1;
    if (abort_it) begin
      Req[w] = 1'b0;
      if (scramble) rand_din();
      step();
      chk("abort_grant", 32'(Grant), 32'd0);
      chk("abort_ack",   32'(Ack),   32'd0);
      chk("abort_q",     32'(Q),     32'(m_q));
      chk("abort_busy",  32'(Busy),  32'd0);
      chk("abort_owner", 32'(Owner), 32'(w));
    end else begin
      step();
      chk("load_q",     32'(Q),     32'(exp_d));
      chk("load_ack",   32'(Ack),   32'(oh(w)));
      chk("load_grant", 32'(Grant), 32'(oh(w)));
      chk("load_busy",  32'(Busy),  32'd1);
      m_q   = exp_d;
      m_ptr = (w + 1) % 4;
      if (scramble) rand_din();
      repeat (extra_rel) begin
        step();
        chk("rel_grant", 32'(Grant), 32'(oh(w)));
        chk("rel_ack",   32'(Ack),   32'd0);
        chk("rel_q",     32'(Q),     32'(m_q));
        if (scramble) rand_din();
      end
      Req[w] = 1'b0;
      step();
      chk("end_grant", 32'(Grant), 32'd0);
      chk("end_busy",  32'(Busy),  32'd0);
      chk("end_ack",   32'(Ack),   32'd0);
      chk("end_owner", 32'(Owner), 32'(w));
      chk("end_q",     32'(Q),     32'(m_q));
      if (restore) Req[w] = 1'b1;
    end
  endtask

  initial begin
    int         order [5];
    logic [7:0] expq  [5];
    Resetn   = 1'b0;
    Req      = '0;
    Hold     = 1'b0;
    scramble = 1'b0;
    for (int i = 0; i < 4; i++) din_arr[i] = '0;
    apply_din();
    m_ptr = 0;
    m_q   = '0;

    #1;
    chk("rst_q",     32'(Q),     32'd0);
    chk("rst_grant", 32'(Grant), 32'd0);
    chk("rst_ack",   32'(Ack),   32'd0);
    chk("rst_owner", 32'(Owner), 32'd0);
    chk("rst_busy",  32'(Busy),  32'd0);
    step();
    step();

    // Reset while in RELEASE holding Q=A5.
    Resetn     = 1'b1;
    din_arr[0] = 8'hA5;
    apply_din();
    Req = 4'b0001;
    step();
    chk("pre_grant", 32'(Grant), 32'h1);
    step();
    chk("pre_q",   32'(Q),   32'hA5);
    chk("pre_ack", 32'(Ack), 32'h1);
    #2;
    Resetn = 1'b0;
    #1;
    chk("async_q",     32'(Q),     32'd0);
    chk("async_grant", 32'(Grant), 32'd0);
    chk("async_ack",   32'(Ack),   32'd0);
    chk("async_owner", 32'(Owner), 32'd0);
    chk("async_busy",  32'(Busy),  32'd0);
    m_q   = '0;
    m_ptr = 0;
    step();
    Resetn     = 1'b1;
    din_arr[0] = 8'h5A;
    apply_din();
    txn(0, 1'b0, 1'b0, 1'b0);

    // Single request from requester 2.
    Req        = 4'b0100;
    din_arr[2] = 8'h3C;
    apply_din();
    txn(1, 1'b0, 1'b0, 1'b0);
    chk("single_q", 32'(Q), 32'h3C);

    // Pointer at 3 with only requesters 0 and 1 asking: wrap to 0, then 1.
    Req        = 4'b0011;
    din_arr[0] = 8'h11;
    din_arr[1] = 8'h22;
    apply_din();
    txn(0, 1'b0, 1'b0, 1'b0);
    chk("wrap_first", 32'(Owner), 32'd0);
    txn(0, 1'b0, 1'b0, 1'b0);
    chk("wrap_second", 32'(Owner), 32'd1);

    // Bring the pointer back to 0, then full round robin.
    Req = 4'b1000;
    txn(0, 1'b0, 1'b0, 1'b0);
    din_arr[0] = 8'h10;
    din_arr[1] = 8'h21;
    din_arr[2] = 8'h32;
    din_arr[3] = 8'h43;
    apply_din();
    order = '{0, 1, 2, 3, 0};
    expq  = '{8'h10, 8'h21, 8'h32, 8'h43, 8'h10};
    Req   = 4'b1111;
    for (int i = 0; i < 5; i++) begin
      txn(0, 1'b0, 1'b0, 1'b1);
      chk("rr_owner", 32'(Owner), 32'(order[i]));
      chk("rr_q",     32'(Q),     32'(expq[i]));
    end
    Req = '0;

    // Hold blocks new grants for 10 cycles.
    Hold = 1'b1;
    Req  = 4'b0010;
    repeat (10) begin
      step();
      chk("hold_grant", 32'(Grant), 32'd0);
      chk("hold_busy",  32'(Busy),  32'd0);
    end
    Hold = 1'b0;
    txn(0, 1'b0, 1'b0, 1'b0);

    // Hold raised during LOAD does not stop the write.
    Req = 4'b0001;
    txn(0, 1'b0, 1'b1, 1'b0);
    Hold = 1'b0;

    // Abort keeps the pointer: next contest with all requesting picks the same start.
    Req = 4'b0010;
    txn(0, 1'b1, 1'b0, 1'b0);
    Req = 4'b1111;
    txn(0, 1'b0, 1'b0, 1'b0);
    chk("abort_ptr", 32'(Owner), 32'd1);
    Req = '0;

    // Randomized transactions against the reference model.
    scramble = 1'b1;
    for (int it = 0; it < 60; it++) begin
      int gap;
      gap = int'($urandom_range(0, 2));
      Req = '0;
      repeat (gap) begin
        step();
        chk("gap_busy",  32'(Busy),  32'd0);
        chk("gap_grant", 32'(Grant), 32'd0);
      end
      if ($urandom_range(0, 3) == 0) begin
        Hold = 1'b1;
        Req  = 4'($urandom_range(1, 15));
        repeat (int'($urandom_range(1, 3))) begin
          step();
          chk("rhold_grant", 32'(Grant), 32'd0);
        end
        Hold = 1'b0;
      end
      rand_din();
      Req = 4'($urandom_range(1, 15));
      txn(int'($urandom_range(0, 2)), ($urandom_range(0, 4) == 0),
          ($urandom_range(0, 3) == 0), 1'b0);
      Hold = 1'b0;
      Req  = '0;
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
